// File: rtl/load_unit_ctrl_if.sv
// Load unit bus bundle: load request, data-memory read port and load response.
// Ports:
//   ld_valid/ld_ready/addr/funct3  load request handshake from the MEM stage
//   mem_req/mem_addr/mem_ack/mem_rdata  word read port to data memory
//   rsp_valid/rsp_data/split  load result and split-access indicator
// slave = the load unit, master = requester plus memory (testbench side).
interface load_unit_ctrl_if;
    logic        ld_valid;
    logic        ld_ready;
    logic [31:0] addr;
    logic [2:0]  funct3;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        split;

    modport slave (
        input  ld_valid, addr, funct3, mem_ack, mem_rdata,
        output ld_ready, mem_req, mem_addr, rsp_valid, rsp_data, split
    );

    modport master (
        output ld_valid, addr, funct3, mem_ack, mem_rdata,
        input  ld_ready, mem_req, mem_addr, rsp_valid, rsp_data, split
    );
endinterface

// File: rtl/load_unit_ctrl.sv
// Sequential RV32I load path: accepts one load, issues one or two word-aligned
// reads (two when the access straddles a word boundary), then extracts and
// sign/zero-extends the result.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    load_unit_ctrl_if.slave (request, memory read port, response)
module load_unit_ctrl (
    input logic            clk,
    input logic            reset,
    load_unit_ctrl_if.slave bus
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {IDLE, RD0, RD1, DONE} state_t;

    state_t      state;
    logic [31:0] addr_q;
    logic [2:0]  funct3_q;
    logic [31:0] w0_q;

    function automatic logic f3_valid(input logic [2:0] f);
        return (f == F3_LB) || (f == F3_LH) || (f == F3_LW) ||
               (f == F3_LBU) || (f == F3_LHU);
    endfunction

    // A half straddles only at offset 3; a word straddles at any non-zero offset.
    function automatic logic needs_split(input logic [2:0] f, input logic [1:0] off);
        case (f)
            F3_LH, F3_LHU: return off == 2'b11;
            F3_LW:         return off != 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

    // Shift the two-word window down to the addressed byte, then size/extend.
    function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] off,
                                            input logic [31:0] w1, input logic [31:0] w0);
        logic [63:0] sh;
        sh = {w1, w0} >> {off, 3'b000};
        case (f)
            F3_LB:   return {{24{sh[7]}}, sh[7:0]};
            F3_LBU:  return {24'h0, sh[7:0]};
            F3_LH:   return {{16{sh[15]}}, sh[15:0]};
            F3_LHU:  return {16'h0, sh[15:0]};
            F3_LW:   return sh[31:0];
            default: return 32'h0;
        endcase
    endfunction

    // Control FSM with registered outputs; ack is only honoured in RD0/RD1.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_q        <= 32'h0;
            funct3_q      <= 3'b000;
            w0_q          <= 32'h0;
            bus.ld_ready  <= 1'b1;
            bus.mem_req   <= 1'b0;
            bus.mem_addr  <= 32'h0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 32'h0;
            bus.split     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.ld_valid) begin
                        addr_q       <= bus.addr;
                        funct3_q     <= bus.funct3;
                        bus.ld_ready <= 1'b0;
                        if (!f3_valid(bus.funct3)) begin
                            bus.rsp_data  <= 32'h0;
                            bus.rsp_valid <= 1'b1;
                            state         <= DONE;
                        end else begin
                            bus.split    <= needs_split(bus.funct3, bus.addr[1:0]);
                            bus.mem_req  <= 1'b1;
                            bus.mem_addr <= {bus.addr[31:2], 2'b00};
                            state        <= RD0;
                        end
                    end
                end
                RD0: begin
                    if (bus.mem_ack) begin
                        w0_q <= bus.mem_rdata;
                        if (bus.split) begin
                            // Wraps modulo 2^32 at the top of the address space.
                            bus.mem_addr <= {addr_q[31:2], 2'b00} + 32'd4;
                            state        <= RD1;
                        end else begin
                            bus.mem_req   <= 1'b0;
                            bus.mem_addr  <= 32'h0;
                            bus.rsp_data  <= extract(funct3_q, addr_q[1:0], 32'h0, bus.mem_rdata);
                            bus.rsp_valid <= 1'b1;
                            state         <= DONE;
                        end
                    end
                end
                RD1: begin
                    if (bus.mem_ack) begin
                        bus.mem_req   <= 1'b0;
                        bus.mem_addr  <= 32'h0;
                        bus.rsp_data  <= extract(funct3_q, addr_q[1:0], bus.mem_rdata, w0_q);
                        bus.rsp_valid <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    bus.rsp_valid <= 1'b0;
                    bus.split     <= 1'b0;
                    bus.ld_ready  <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
